// File: rtl/knn_topk_sort.sv
// Streaming top-K selector: keeps the K nearest samples of a frame in a sorted insertion list, then drains them in rank order.
// Define KNN_TOPK_DESCENDING_EN to keep the K largest distances instead, drained in descending order.
module knn_topk_sort #(
   parameter int K  = 8,
   parameter int DW = 32,
   parameter int TW = 32,
   parameter int CW = $clog2(K + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_distance,
   input  logic [TW-1:0] in_type,
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_distance,
   output logic [TW-1:0] out_type,
   output logic [CW-1:0] out_index,
   output logic          out_last
);

   typedef enum logic {S_LOAD, S_DRAIN} state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] dist_q [K];
   logic [DW-1:0] dist_d [K];
   logic [TW-1:0] typ_q  [K];
   logic [TW-1:0] typ_d  [K];
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] rd_q, rd_d;

   logic          accept;
   logic [CW-1:0] p;
   logic [DW-1:0] rd_dist;
   logic [TW-1:0] rd_typ;

   // An already stored entry ranks ahead of the incoming sample when this holds; ties favour the stored (earlier) one.
   function automatic logic ranks_first(input logic [DW-1:0] stored, input logic [DW-1:0] incoming);
`ifdef KNN_TOPK_DESCENDING_EN
      return stored >= incoming;
`else
      return stored <= incoming;
`endif
   endfunction

   assign accept = in_valid && (state_q == S_LOAD);

   always_comb begin
      p = '0;
      for (int i = 0; i < K; i++) begin
         if (CW'(i) < count_q && ranks_first(dist_q[i], in_distance))
            p = p + CW'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      rd_d    = rd_q;
      dist_d  = dist_q;
      typ_d   = typ_q;
      if (state_q == S_LOAD) begin
         if (accept) begin
            if (p < CW'(K)) begin
               // Shift the tail down one slot; the old last entry falls off when the list is full.
               for (int i = 1; i < K; i++) begin
                  if (CW'(i) > p) begin
                     dist_d[i] = dist_q[i-1];
                     typ_d[i]  = typ_q[i-1];
                  end
               end
               for (int i = 0; i < K; i++) begin
                  if (CW'(i) == p) begin
                     dist_d[i] = in_distance;
                     typ_d[i]  = in_type;
                  end
               end
               count_d = (count_q == CW'(K)) ? count_q : count_q + CW'(1);
            end
            if (in_last) begin
               state_d = S_DRAIN;
               rd_d    = '0;
            end
         end
      end else if (out_ready) begin
         if (out_last) begin
            state_d = S_LOAD;
            count_d = '0;
            rd_d    = '0;
         end else begin
            rd_d = rd_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_LOAD;
         count_q <= '0;
         rd_q    <= '0;
         for (int i = 0; i < K; i++) begin
            dist_q[i] <= '0;
            typ_q[i]  <= '0;
         end
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         rd_q    <= rd_d;
         dist_q  <= dist_d;
         typ_q   <= typ_d;
      end
   end

   always_comb begin
      rd_dist = '0;
      rd_typ  = '0;
      for (int i = 0; i < K; i++) begin
         if (rd_q == CW'(i)) begin
            rd_dist = dist_q[i];
            rd_typ  = typ_q[i];
         end
      end
   end

   // Drain outputs are forced to zero while loading so stale list contents never leak out.
   assign in_ready     = (state_q == S_LOAD);
   assign out_valid    = (state_q == S_DRAIN);
   assign out_distance = out_valid ? rd_dist : '0;
   assign out_type     = out_valid ? rd_typ : '0;
   assign out_index    = out_valid ? rd_q : '0;
   assign out_last     = out_valid && (rd_q == count_q - CW'(1));

endmodule

// File: tb/tb_knn_topk_sort.sv
// Scoreboard bench for knn_topk_sort (K=4): directed frames, backpressure, mid-drain reset and randomized frames.
module tb_knn_topk_sort;

   localparam int K  = 4;
   localparam int DW = 32;
   localparam int TW = 32;
   localparam int CW = $clog2(K + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_distance = '0;
   logic [TW-1:0] in_type = '0;
   logic          in_last = 1'b0;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_distance;
   logic [TW-1:0] out_type;
   logic [CW-1:0] out_index;
   logic          out_last;

   logic readyForce = 1'b1;
   logic randReady  = 1'b0;
   logic randBit    = 1'b1;
   assign out_ready = randReady ? randBit : readyForce;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [TW-1:0] t;
      logic [CW-1:0] idx;
      logic          last;
   } exp_t;

   exp_t          expQ[$];
   logic [DW-1:0] frameD[$];
   logic [TW-1:0] frameT[$];
   int            checks = 0;
   int            errors = 0;

   knn_topk_sort #(.K(K), .DW(DW), .TW(TW), .CW(CW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_distance(in_distance),
      .in_type(in_type), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_distance(out_distance),
      .out_type(out_type), .out_index(out_index), .out_last(out_last)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      randBit = 1'($urandom_range(0, 1));
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference: pick the best remaining sample K times; strict compare keeps the earliest sample on ties.
   function automatic bit better(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef KNN_TOPK_DESCENDING_EN
      return a > b;
`else
      return a < b;
`endif
   endfunction

   task automatic modelFrame();
      int n = frameD.size();
      int keep = (n < K) ? n : K;
      bit taken[] = new[n];
      for (int r = 0; r < keep; r++) begin
         int best = -1;
         exp_t e;
         for (int j = 0; j < n; j++)
            if (!taken[j] && (best < 0 || better(frameD[j], frameD[best])))
               best = j;
         taken[best] = 1'b1;
         e.d    = frameD[best];
         e.t    = frameT[best];
         e.idx  = CW'(r);
         e.last = (r == keep - 1);
         expQ.push_back(e);
      end
      frameD.delete();
      frameT.delete();
   endtask

   // Drives one sample and returns at posedge+1 after it was accepted.
   task automatic applyStimulus(input logic [DW-1:0] d, input logic [TW-1:0] t, input logic last);
      int waitCnt = 0;
      in_valid    = 1'b1;
      in_distance = d;
      in_type     = t;
      in_last     = last;
      @(negedge clk);
      while (!in_ready && waitCnt < 200) begin
         waitCnt++;
         @(negedge clk);
      end
      if (!in_ready) begin
         checkOutput("accept_timeout", 64'(in_ready), 64'd1);
         in_valid = 1'b0;
         in_last  = 1'b0;
         return;
      end
      frameD.push_back(d);
      frameT.push_back(t);
      if (last) modelFrame();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic waitDrainDone(input string name);
      int waitCnt = 0;
      while ((expQ.size() != 0 || out_valid) && waitCnt < 300) begin
         waitCnt++;
         @(posedge clk);
         #1;
      end
      checkOutput({name, "_drain_done"}, 64'(expQ.size() == 0 && !out_valid), 64'd1);
      checkOutput({name, "_ready_after"}, 64'(in_ready), 64'd1);
   endtask

   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_out", {32'd0, out_distance}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("out_distance", 64'(out_distance), 64'(e.d));
            checkOutput("out_type", 64'(out_type), 64'(e.t));
            checkOutput("out_index", 64'(out_index), 64'(e.idx));
            checkOutput("out_last", 64'(out_last), 64'(e.last));
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired actual=running required=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      // Reset held two cycles with a sample offered; nothing may be stored.
      in_valid    = 1'b1;
      in_distance = 32'd99;
      in_type     = 32'd77;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_out_distance", 64'(out_distance), 64'd0);
      checkOutput("rst_out_type", 64'(out_type), 64'd0);
      checkOutput("rst_out_index", 64'(out_index), 64'd0);
      checkOutput("rst_out_last", 64'(out_last), 64'd0);
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(32'd9, 32'd7, 1'b1);
      waitDrainDone("after_reset");

      applyStimulus(32'd50, 32'd1, 1'b0);
      applyStimulus(32'd10, 32'd2, 1'b0);
      applyStimulus(32'd40, 32'd3, 1'b0);
      applyStimulus(32'd30, 32'd4, 1'b0);
      applyStimulus(32'd20, 32'd5, 1'b0);
      applyStimulus(32'd60, 32'd6, 1'b1);
      checkOutput("drain_latency", 64'(out_valid), 64'd1);
      checkOutput("drain_first_dist", 64'(out_distance), 64'd10);
      waitDrainDone("frame6");

      applyStimulus(32'd7, 32'd1, 1'b0);
      applyStimulus(32'd3, 32'd2, 1'b1);
      waitDrainDone("short");

      for (int i = 1; i <= 5; i++)
         applyStimulus(32'd5, TW'(i), i == 5);
      waitDrainDone("ties");

      // Backpressure at rank 1, then abort the drain with reset.
      readyForce = 1'b0;
      applyStimulus(32'd50, 32'd1, 1'b0);
      applyStimulus(32'd10, 32'd2, 1'b0);
      applyStimulus(32'd40, 32'd3, 1'b0);
      applyStimulus(32'd30, 32'd4, 1'b0);
      applyStimulus(32'd20, 32'd5, 1'b0);
      applyStimulus(32'd60, 32'd6, 1'b1);
      readyForce = 1'b1;
      @(posedge clk);
      #1;
      readyForce = 1'b0;
      for (int c = 0; c < 3; c++) begin
         in_valid    = 1'b1;
         in_distance = $urandom;
         in_type     = $urandom;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
`ifndef KNN_TOPK_DESCENDING_EN
         checkOutput("hold_distance", 64'(out_distance), 64'd20);
         checkOutput("hold_type", 64'(out_type), 64'd5);
`endif
         checkOutput("hold_index", 64'(out_index), 64'd1);
         checkOutput("hold_valid", 64'(out_valid), 64'd1);
         checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
      end
      rst = 1'b0;
      expQ.delete();
      frameD.delete();
      frameT.delete();
      @(posedge clk);
      #1;
      rst = 1'b1;
      checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
      checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
      readyForce = 1'b1;
      applyStimulus(32'd8, 32'd1, 1'b1);
      waitDrainDone("after_abort");

      // Randomized frames with small distances for frequent ties and random backpressure.
      randReady = 1'b1;
      for (int f = 0; f < 25; f++) begin
         int len = $urandom_range(1, 10);
         for (int s = 0; s < len; s++) begin
            if ($urandom_range(0, 3) == 0) begin
               @(posedge clk);
               #1;
            end
            applyStimulus(DW'($urandom_range(0, 15)), $urandom, s == len - 1);
         end
         waitDrainDone("random");
      end
      randReady = 1'b0;

      checkOutput("final_queue_empty", 64'(expQ.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
